data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage load/store front end to a single-beat external bus.
// An aligned access is latched in IDLE, presented in REQ until bus_ack, and
// released in DONE. A misaligned access only pulses mem_misalign.
// Optional build macro DMEM_TIMEOUT_EN adds a bus-wait timeout with an ABORT
// state and a sticky bus_err flag.
module data_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

`ifdef DMEM_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ABORT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic        access, aligned_acc;
  logic        release_cyc;

  assign access       = mem_ren | mem_wen;
  assign aligned_acc  = access & (mem_addr[1:0] == 2'b00);
  assign mem_misalign = access & (mem_addr[1:0] != 2'b00);

`ifdef DMEM_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] to_cnt;
  logic        to_hit;
  logic        err_q;

  // Timeout fires on the REQ cycle whose miss would bring the count to the limit.
  assign to_hit      = (state == S_REQ) & ~bus_ack & (to_cnt + 16'd1 == TO_LIM);
  assign release_cyc = (state == S_DONE) | (state == S_ABORT);
  assign bus_err     = err_q;

  // Wait counter (cleared on REQ entry) and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && aligned_acc) to_cnt <= '0;
      else if (state == S_REQ && !bus_ack) to_cnt <= to_cnt + 16'd1;
      if (to_hit) err_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_CYCLES;
  assign release_cyc = (state == S_DONE);
  assign bus_err     = 1'b0;
`endif

  // Pipeline is held until the release cycle of the access it is presenting.
  assign mem_stall = aligned_acc & ~release_cyc;
  assign bus_req   = (state == S_REQ);
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = we_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (aligned_acc) state_nxt = S_REQ;
      S_REQ: begin
        if (bus_ack) state_nxt = S_DONE;
`ifdef DMEM_TIMEOUT_EN
        else if (to_hit) state_nxt = S_ABORT;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request latch on IDLE->REQ and read-data capture on a read's ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mem_din <= '0;
    end else begin
      if (state == S_IDLE && aligned_acc) begin
        addr_q  <= {mem_addr[31:2], 2'b00};
        wdata_q <= mem_dout;
        we_q    <= mem_wen;
      end
      if (state == S_REQ && bus_ack && !we_q) mem_din <= bus_rdata;
    end
  end

endmodule
